// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 width codes, response
// error codes and the controller state enum.
package lsu_pkg;

    // RV32I load/store width codes (bit 2 selects zero-extension on loads)
    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [1:0] {
        ErrNone       = 2'b00,
        ErrMisaligned = 2'b01,
        ErrTimeout    = 2'b10,
        ErrIllegal    = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic: request legality checks, store strobes and
// lane placement, and load byte/halfword selection with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        write_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_off_i,
    input  logic [31:0] wdata_i,
    output logic        illegal_o,
    output logic        misaligned_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [3:0]  strb_base;
    logic [4:0]  st_shamt;
    logic [4:0]  ld_shamt;
    logic [31:0] ld_shifted;

    assign st_shamt = {addr_off_i, 3'b000};
    assign ld_shamt = {ld_off_i, 3'b000};

    // Classify the incoming request and build the store lane image
    always_comb begin
        if (write_i) begin
            illegal_o = !(funct3_i inside {F3Byte, F3Half, F3Word});
        end else begin
            illegal_o = !(funct3_i inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU});
        end

        misaligned_o = 1'b0;
        strb_base    = 4'b1111;
        wdata_o      = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                strb_base = 4'b0001;
                wdata_o   = {24'b0, wdata_i[7:0]} << st_shamt;
            end
            2'b01: begin
                misaligned_o = addr_off_i[0];
                strb_base    = 4'b0011;
                wdata_o      = {16'b0, wdata_i[15:0]} << st_shamt;
            end
            default: begin
                misaligned_o = (addr_off_i != 2'b00);
            end
        endcase

        wstrb_o = write_i ? (strb_base << addr_off_i) : 4'b0000;
        if (!write_i) begin
            wdata_o = 32'b0;
        end
    end

    assign ld_shifted = ld_rdata_i >> ld_shamt;

    // Extract and extend the addressed load lane
    always_comb begin
        case (ld_funct3_i)
            F3Byte:  ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3ByteU: ld_data_o = {24'b0, ld_shifted[7:0]};
            F3Half:  ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3HalfU: ld_data_o = {16'b0, ld_shifted[15:0]};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one access from execute,
// drives a request/ack data-memory port with timeout, returns a one-cycle
// response carrying aligned load data or an error code.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]  resp_err_q, resp_err_d;

    logic        al_illegal;
    logic        al_misaligned;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_ld_data;

    lsu_align u_align (
        .write_i      (req_write),
        .funct3_i     (req_funct3),
        .addr_off_i   (req_addr[1:0]),
        .wdata_i      (req_wdata),
        .illegal_o    (al_illegal),
        .misaligned_o (al_misaligned),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .ld_funct3_i  (funct3_q),
        .ld_off_i     (off_q),
        .ld_rdata_i   (mem_rdata),
        .ld_data_o    (al_ld_data)
    );

    assign cnt_inc = cnt_q + CntW'(1);

    // Next-state, memory port and response computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        // Response fields are only non-zero during the single RESP cycle
        resp_rdata_d = 32'b0;
        resp_err_d   = ErrNone;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    if (al_illegal) begin
                        state_d    = StResp;
                        resp_err_d = ErrIllegal;
                    end else if (al_misaligned) begin
                        state_d    = StResp;
                        resp_err_d = ErrMisaligned;
                    end else begin
                        state_d     = StAccess;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = al_wdata;
                        mem_wstrb_d = al_wstrb;
                    end
                end
            end
            StAccess: begin
                if (mem_ack || (cnt_inc == CntW'(TIMEOUT_CYCLES))) begin
                    state_d     = StResp;
                    cnt_d       = '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'b0;
                    mem_wdata_d = 32'b0;
                    mem_wstrb_d = 4'b0000;
                    if (mem_ack) begin
                        resp_rdata_d = mem_we_q ? 32'b0 : al_ld_data;
                    end else begin
                        resp_err_d = ErrTimeout;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_wdata_q  <= 32'b0;
            mem_wstrb_q  <= 4'b0000;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= ErrNone;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an arithmetic
// reference model of widths, lanes, extension, errors and timeout.
module tb_load_store_unit;

    localparam int unsigned Timeout = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.TIMEOUT_CYCLES(Timeout)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model ------------------------------------------------------
    function automatic int unsigned size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] exp_err(input bit wr, input logic [2:0] f3,
                                           input logic [31:0] addr);
        bit legal;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b11;
        if ((addr % size_of(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] exp_strb(input bit wr, input logic [2:0] f3,
                                            input logic [31:0] addr);
        longint m;
        if (!wr) return 4'b0000;
        m = ((longint'(1) << size_of(f3)) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        logic [31:0] m = 32'b0;
        for (int i = 0; i < 4; i++) if (strb[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] wd);
        longint v;
        v = longint'(wd) & ((longint'(1) << (8 * size_of(f3))) - 1);
        v = v << (8 * (addr % 4));
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        longint v;
        int unsigned bits;
        bits = 8 * size_of(f3);
        v = longint'(rd) >> (8 * (addr % 4));
        v = v & ((longint'(1) << bits) - 1);
        if (f3[2] == 1'b0 && bits < 32 && ((v >> (bits - 1)) & 1) == 1)
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    // One complete transaction; ack_dly >= Timeout means no ack is given
    task automatic run_access(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_dly, input bit late_ack);
        int guard = 0;
        bit acked = 1'b0;
        logic [1:0] e;
        logic [3:0] strb;
        logic [31:0] msk;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        step();
        // Scramble request fields: the unit must have captured them
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        e = exp_err(wr, f3, addr);
        if (e != 2'b00) begin
            chk("err_resp_valid", 32'(resp_valid), 32'd1);
            chk("err_code", 32'(resp_err), 32'(e));
            chk("err_rdata", resp_rdata, 32'd0);
            chk("err_no_mem_req", 32'(mem_req), 32'd0);
            chk("err_not_ready", 32'(req_ready), 32'd0);
        end else begin
            strb = exp_strb(wr, f3, addr);
            msk  = lane_mask(strb);
            for (int k = 0; k < int'(Timeout); k++) begin
                chk("mem_req_held", 32'(mem_req), 32'd1);
                chk("mem_we", 32'(mem_we), 32'(wr));
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_wstrb", 32'(mem_wstrb), 32'(strb));
                chk("mem_wdata_lanes", mem_wdata & msk, exp_wdata(f3, addr, wd) & msk);
                chk("resp_idle_in_access", 32'(resp_valid), 32'd0);
                if (k == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
                step();
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                if (k == ack_dly) begin
                    acked = 1'b1;
                    break;
                end
            end
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_err", 32'(resp_err), acked ? 32'd0 : 32'd2);
            chk("resp_rdata", resp_rdata,
                (acked && !wr) ? exp_load(f3, addr, rd) : 32'd0);
            chk("mem_req_dropped", 32'(mem_req), 32'd0);
        end
        if (late_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEADBEEF;
        end
        step();
        mem_ack = 1'b0;
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("resp_err_quiet", 32'(resp_err), 32'd0);
        chk("resp_rdata_quiet", resp_rdata, 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        if (late_ack) begin
            step();
            chk("late_ack_ignored_valid", 32'(resp_valid), 32'd0);
            chk("late_ack_ignored_req", 32'(mem_req), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'b0;
        req_wdata = 32'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // SW at 0x10, ack one cycle after mem_req rises
        run_access(1'b1, 3'b010, 32'h10, 32'h8, 32'h0, 1, 1'b0);
        // Load lane selection and extension on 0x80FF7F01
        run_access(1'b0, 3'b000, 32'h3, 32'h0, 32'h80FF7F01, 0, 1'b0);
        run_access(1'b0, 3'b100, 32'h3, 32'h0, 32'h80FF7F01, 2, 1'b0);
        run_access(1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF7F01, 0, 1'b0);
        run_access(1'b0, 3'b101, 32'h0, 32'h0, 32'h80FF7F01, 3, 1'b0);
        run_access(1'b0, 3'b010, 32'h8, 32'h0, 32'h80FF7F01, 0, 1'b0);
        // SB into lane 1 and SH into upper half
        run_access(1'b1, 3'b000, 32'h21, 32'hAB, 32'h0, 0, 1'b0);
        run_access(1'b1, 3'b001, 32'h32, 32'h1234CAFE, 32'h0, 4, 1'b0);
        // Error paths: misaligned word, illegal funct3 on load and store
        run_access(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 1'b0);
        run_access(1'b0, 3'b011, 32'h6, 32'h0, 32'h0, 0, 1'b0);
        run_access(1'b1, 3'b100, 32'h1, 32'h0, 32'h0, 0, 1'b0);
        run_access(1'b1, 3'b001, 32'h5, 32'h0, 32'h0, 0, 1'b0);
        // Timeout with a late ack afterwards, and ack on the last legal cycle
        run_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 100, 1'b1);
        run_access(1'b0, 3'b010, 32'h44, 32'h0, 32'h87654321, int'(Timeout) - 1, 1'b0);

        // Reset in the middle of an access
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h80;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_outputs("mid_reset");
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        chk("post_reset_no_resp", 32'(resp_valid), 32'd0);
        chk("post_reset_no_req", 32'(mem_req), 32'd0);
        chk("post_reset_ready", 32'(req_ready), 32'd1);

        // Randomized accesses
        for (int n = 0; n < 150; n++) begin
            wr   = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            run_access(wr, f3, addr, $urandom, $urandom, int'($urandom_range(0, 19)),
                       1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
